// File: rtl/rs232_rx_framed_if.sv
// Stream side of rs232_rx_framed: one received character plus its error flags per beat.
interface rs232_rx_framed_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] odata;
    logic [2:0]           oerror;
    logic                 ovalid;
    logic                 oready;

    modport master (output odata, output oerror, output ovalid, input oready);
    modport slave  (input odata, input oerror, input ovalid, output oready);
endinterface

// File: rtl/rs232_rx_framed.sv
// Oversampled RS232 receiver with configurable framing, per-character error flags
// and a show-ahead FIFO whose fill level drives RTSn between frames.
module rs232_rx_framed #(
    parameter real CLOCK_FREQ = 133000000.0,
    parameter real BAUD_RATE  = 115200.0,
    parameter int  OVERSAMPLE = 16,
    parameter int  DATA_BITS  = 8,
    parameter int  PARITY     = 0,
    parameter int  STOP_BITS  = 1,
    parameter int  BUFFER     = 4,
    parameter int  RTS_LEVEL  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rxd_pin,
    output logic              rtsn_pin,
    output logic              overflow,
    rs232_rx_framed_if.master stream
);
    localparam int DIV   = int'(CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE));
    localparam int DivW  = $clog2(DIV);
    localparam int SampW = $clog2(OVERSAMPLE);
    localparam int BitW  = $clog2(DATA_BITS);
    localparam int PtrW  = $clog2(BUFFER);
    localparam int CntW  = $clog2(BUFFER + 1);
    localparam int WordW = DATA_BITS + 3;

    generate
        if (DIV < 2 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
            PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 || BUFFER < 2 ||
            RTS_LEVEL < 1 || RTS_LEVEL > BUFFER) begin : gParamCheck
            $fatal(1, "rs232_rx_framed: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP1, STOP2, BRKWAIT} state_t;

    state_t               state_q, state_d;
    logic                 rxdMeta_q, rxdSync_q;
    logic [DivW-1:0]      divCnt_q, divCnt_d;
    logic [SampW-1:0]     sampCnt_q, sampCnt_d, sampNext;
    logic [1:0]           vote_q, vote_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BitW-1:0]      bitCnt_q, bitCnt_d;
    logic                 allZero_q, allZero_d;
    logic                 parErr_q, parErr_d;
    logic                 frameErr_q, frameErr_d;
    logic                 pushReq_q, pushReq_d;
    logic [WordW-1:0]     pushWord_q, pushWord_d;
    logic                 tick, bitDecide, majority;

    logic [WordW-1:0]     mem_q [BUFFER];
    logic [PtrW-1:0]      wrPtr_q, rdPtr_q;
    logic [CntW-1:0]      count_q;
    logic                 rtsn_q, overflow_q;
    logic                 pop, full, pushOk;

    function automatic logic [PtrW-1:0] ptrInc(input logic [PtrW-1:0] p);
        return (p == PtrW'(BUFFER - 1)) ? '0 : p + 1'b1;
    endfunction

    // Tick numbering counts 1..OVERSAMPLE-1 then 0 at the bit boundary, so the vote window sits on mid-bit.
    assign tick      = (divCnt_q == DivW'(DIV - 1));
    assign sampNext  = (sampCnt_q == SampW'(OVERSAMPLE - 1)) ? '0 : sampCnt_q + 1'b1;
    assign bitDecide = tick && (sampNext == SampW'(OVERSAMPLE / 2 + 1));
    assign majority  = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxdSync_q) | (vote_q[1] & rxdSync_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            rxdMeta_q  <= 1'b1;
            rxdSync_q  <= 1'b1;
            state_q    <= IDLE;
            divCnt_q   <= '0;
            sampCnt_q  <= '0;
            vote_q     <= '0;
            shift_q    <= '0;
            bitCnt_q   <= '0;
            allZero_q  <= 1'b1;
            parErr_q   <= 1'b0;
            frameErr_q <= 1'b0;
            pushReq_q  <= 1'b0;
            pushWord_q <= '0;
        end else begin
            rxdMeta_q  <= rxd_pin;
            rxdSync_q  <= rxdMeta_q;
            state_q    <= state_d;
            divCnt_q   <= divCnt_d;
            sampCnt_q  <= sampCnt_d;
            vote_q     <= vote_d;
            shift_q    <= shift_d;
            bitCnt_q   <= bitCnt_d;
            allZero_q  <= allZero_d;
            parErr_q   <= parErr_d;
            frameErr_q <= frameErr_d;
            pushReq_q  <= pushReq_d;
            pushWord_q <= pushWord_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        divCnt_d   = tick ? '0 : divCnt_q + 1'b1;
        sampCnt_d  = tick ? sampNext : sampCnt_q;
        vote_d     = vote_q;
        shift_d    = shift_q;
        bitCnt_d   = bitCnt_q;
        allZero_d  = allZero_q;
        parErr_d   = parErr_q;
        frameErr_d = frameErr_q;
        pushReq_d  = 1'b0;
        pushWord_d = pushWord_q;
        if (tick && sampNext == SampW'(OVERSAMPLE / 2 - 1)) vote_d[0] = rxdSync_q;
        if (tick && sampNext == SampW'(OVERSAMPLE / 2))     vote_d[1] = rxdSync_q;
        case (state_q)
            IDLE: begin
                if (!rxdSync_q) begin
                    state_d    = START;
                    divCnt_d   = '0;
                    sampCnt_d  = '0;
                    bitCnt_d   = '0;
                    allZero_d  = 1'b1;
                    parErr_d   = 1'b0;
                    frameErr_d = 1'b0;
                end
            end
            START: begin
                if (bitDecide) state_d = majority ? IDLE : DATA;
            end
            DATA: begin
                if (bitDecide) begin
                    shift_d   = {majority, shift_q[DATA_BITS-1:1]};
                    allZero_d = allZero_q & ~majority;
                    if (bitCnt_q == BitW'(DATA_BITS - 1)) state_d = (PARITY != 0) ? PAR : STOP1;
                    else                                  bitCnt_d = bitCnt_q + 1'b1;
                end
            end
            PAR: begin
                if (bitDecide) begin
                    allZero_d = allZero_q & ~majority;
                    parErr_d  = (PARITY == 1) ? ~(^shift_q ^ majority) : (^shift_q ^ majority);
                    state_d   = STOP1;
                end
            end
            STOP1: begin
                // A break ends the character at the first stop bit even with two stop bits configured.
                if (bitDecide) begin
                    if (allZero_q && !majority) begin
                        pushReq_d  = 1'b1;
                        pushWord_d = {3'b110, {DATA_BITS{1'b0}}};
                        state_d    = BRKWAIT;
                    end else begin
                        frameErr_d = ~majority;
                        if (STOP_BITS == 2) begin
                            state_d = STOP2;
                        end else begin
                            pushReq_d  = 1'b1;
                            pushWord_d = {1'b0, ~majority, parErr_q, shift_q};
                            state_d    = IDLE;
                        end
                    end
                end
            end
            STOP2: begin
                if (bitDecide) begin
                    pushReq_d  = 1'b1;
                    pushWord_d = {1'b0, frameErr_q | ~majority, parErr_q, shift_q};
                    state_d    = IDLE;
                end
            end
            BRKWAIT: begin
                if (rxdSync_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A push into a full FIFO still lands when the consumer frees a slot in the same cycle.
    assign pop    = (count_q != '0) && stream.oready;
    assign full   = (count_q == CntW'(BUFFER));
    assign pushOk = pushReq_q && (!full || pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < BUFFER; i++) mem_q[i] <= '0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            rtsn_q     <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (pushOk) begin
                mem_q[wrPtr_q] <= pushWord_q;
                wrPtr_q        <= ptrInc(wrPtr_q);
            end
            if (pop) rdPtr_q <= ptrInc(rdPtr_q);
            if (pushOk && !pop)      count_q <= count_q + 1'b1;
            else if (!pushOk && pop) count_q <= count_q - 1'b1;
            if (pushReq_q && !pushOk) overflow_q <= 1'b1;
            if (state_q == IDLE) rtsn_q <= (count_q >= CntW'(RTS_LEVEL));
        end
    end

    assign stream.odata  = mem_q[rdPtr_q][DATA_BITS-1:0];
    assign stream.oerror = mem_q[rdPtr_q][WordW-1:DATA_BITS];
    assign stream.ovalid = (count_q != '0);
    assign rtsn_pin      = rtsn_q;
    assign overflow      = overflow_q;
endmodule

// File: tb/tb_rs232_rx_framed.sv
// Directed bench for rs232_rx_framed: an 8N1 receiver and an 8E1 receiver at DIV=10, 160 clocks per bit.
module tb_rs232_rx_framed;
    localparam int BitCycles = 160;

    logic clock = 1'b0;
    logic reset;
    logic rxdA, rxdB;
    logic rtsnA, rtsnB, overflowA, overflowB;

    rs232_rx_framed_if #(.DATA_BITS(8)) streamA ();
    rs232_rx_framed_if #(.DATA_BITS(8)) streamB ();

    always #5 clock = ~clock;

    rs232_rx_framed #(
        .CLOCK_FREQ(18432000.0), .BAUD_RATE(115200.0), .OVERSAMPLE(16), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .BUFFER(4), .RTS_LEVEL(2)
    ) dutA (
        .clock(clock), .reset(reset), .rxd_pin(rxdA), .rtsn_pin(rtsnA),
        .overflow(overflowA), .stream(streamA)
    );

    rs232_rx_framed #(
        .CLOCK_FREQ(18432000.0), .BAUD_RATE(115200.0), .OVERSAMPLE(16), .DATA_BITS(8),
        .PARITY(2), .STOP_BITS(1), .BUFFER(4), .RTS_LEVEL(2)
    ) dutB (
        .clock(clock), .reset(reset), .rxd_pin(rxdB), .rtsn_pin(rtsnB),
        .overflow(overflowB), .stream(streamB)
    );

    int testsRun = 0;
    int failCount = 0;
    int cycle = 0;
    int frameStart = 0;
    int capCycleA = 0;
    int validCyclesA = 0;
    int baseValid;
    logic [10:0] wordsA[$];
    logic [10:0] wordsB[$];

    always @(posedge clock) cycle <= cycle + 1;

    // Accepted beats are logged as {oerror, odata} on the falling edge, clear of the active edge.
    always @(negedge clock) begin
        if (streamA.ovalid) validCyclesA <= validCyclesA + 1;
        if (streamA.ovalid && streamA.oready) begin
            wordsA.push_back({streamA.oerror, streamA.odata});
            capCycleA <= cycle;
        end
        if (streamB.ovalid && streamB.oready) wordsB.push_back({streamB.oerror, streamB.odata});
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic driveLine(input bit toB, input logic v);
        if (toB) rxdB = v;
        else     rxdA = v;
    endtask

    task automatic applyStimulus(input bit toB, input logic [15:0] bits, input int nBits, input int idleBits);
        @(posedge clock); #1;
        frameStart = cycle;
        for (int i = 0; i < nBits; i++) begin
            driveLine(toB, bits[i]);
            repeat (BitCycles) @(posedge clock);
            #1;
        end
        driveLine(toB, 1'b1);
        repeat (idleBits * BitCycles) @(posedge clock);
        #1;
    endtask

    function automatic logic [15:0] frame8N1(input logic [7:0] d, input logic stopBit);
        return {6'b0, stopBit, d, 1'b0};
    endfunction

    function automatic logic [15:0] frame8E1(input logic [7:0] d, input logic parBit);
        return {5'b0, 1'b1, parBit, d, 1'b0};
    endfunction

    initial begin
        rxdA = 1'b1;
        rxdB = 1'b1;
        streamA.oready = 1'b0;
        streamB.oready = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("reset_rtsn", rtsnA, 1);
        checkOutput("reset_ovalid", streamA.ovalid, 0);
        checkOutput("reset_odata", streamA.odata, 0);
        checkOutput("reset_oerror", streamA.oerror, 0);
        checkOutput("reset_overflow", overflowA, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        checkOutput("rtsn_after_reset", rtsnA, 0);

        // 8N1 0xA5 with the consumer ready
        streamA.oready = 1'b1;
        wordsA.delete();
        baseValid = validCyclesA;
        applyStimulus(0, frame8N1(8'hA5, 1'b1), 10, 2);
        checkOutput("a5_count", wordsA.size(), 1);
        checkOutput("a5_word", wordsA[0], 11'h0A5);
        checkOutput("a5_latency_window", ((capCycleA - frameStart) >= 1523 && (capCycleA - frameStart) <= 1543), 1);
        checkOutput("a5_valid_cycles", validCyclesA - baseValid, 1);

        // 40-cycle glitch is a false start
        wordsA.delete();
        @(posedge clock); #1;
        rxdA = 1'b0;
        repeat (40) @(posedge clock);
        #1;
        rxdA = 1'b1;
        repeat (400) @(posedge clock);
        #1;
        checkOutput("glitch_no_word", wordsA.size(), 0);

        // 0x55 with a low stop bit
        wordsA.delete();
        applyStimulus(0, frame8N1(8'h55, 1'b0), 10, 2);
        checkOutput("framing_count", wordsA.size(), 1);
        checkOutput("framing_word", wordsA[0], 11'h255);

        // Break: 12 bit times low
        wordsA.delete();
        @(posedge clock); #1;
        rxdA = 1'b0;
        repeat (12 * BitCycles) @(posedge clock);
        #1;
        rxdA = 1'b1;
        repeat (3 * BitCycles) @(posedge clock);
        #1;
        checkOutput("break_count", wordsA.size(), 1);
        checkOutput("break_word", wordsA[0], 11'h600);
        wordsA.delete();
        applyStimulus(0, frame8N1(8'h41, 1'b1), 10, 2);
        checkOutput("after_break_count", wordsA.size(), 1);
        checkOutput("after_break_word", wordsA[0], 11'h041);

        // Backpressure: five characters into a four-deep FIFO
        streamA.oready = 1'b0;
        wordsA.delete();
        applyStimulus(0, frame8N1(8'h01, 1'b1), 10, 2);
        checkOutput("bp_rtsn_one_word", rtsnA, 0);
        applyStimulus(0, frame8N1(8'h02, 1'b1), 10, 2);
        checkOutput("bp_rtsn_two_words", rtsnA, 1);
        checkOutput("bp_overflow_not_yet", overflowA, 0);
        applyStimulus(0, frame8N1(8'h03, 1'b1), 10, 2);
        applyStimulus(0, frame8N1(8'h04, 1'b1), 10, 2);
        applyStimulus(0, frame8N1(8'h05, 1'b1), 10, 2);
        checkOutput("bp_overflow", overflowA, 1);
        checkOutput("bp_head_data", streamA.odata, 8'h01);
        checkOutput("bp_no_pop", wordsA.size(), 0);
        streamA.oready = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        checkOutput("drain_count", wordsA.size(), 4);
        for (int i = 0; i < 4; i++) checkOutput($sformatf("drain_word%0d", i), wordsA[i], 11'(i + 1));
        checkOutput("drain_ovalid", streamA.ovalid, 0);
        checkOutput("drain_rtsn", rtsnA, 0);
        checkOutput("overflow_sticky", overflowA, 1);

        // Reset for one cycle in the middle of 0x3C's data bits
        wordsA.delete();
        applyStimulus(0, frame8N1(8'h3C, 1'b1), 5, 0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        checkOutput("midreset_rtsn", rtsnA, 1);
        checkOutput("midreset_overflow", overflowA, 0);
        checkOutput("midreset_ovalid", streamA.ovalid, 0);
        checkOutput("midreset_odata", streamA.odata, 0);
        checkOutput("midreset_oerror", streamA.oerror, 0);
        repeat (12 * BitCycles) @(posedge clock);
        #1;
        checkOutput("midreset_no_word", wordsA.size(), 0);
        applyStimulus(0, frame8N1(8'hC3, 1'b1), 10, 2);
        checkOutput("after_reset_count", wordsA.size(), 1);
        checkOutput("after_reset_word", wordsA[0], 11'h0C3);

        // Even parity: 0x03 has two ones, so parity bit 1 is wrong and 0 is right
        wordsB.delete();
        applyStimulus(1, frame8E1(8'h03, 1'b1), 11, 2);
        checkOutput("even_bad_count", wordsB.size(), 1);
        checkOutput("even_bad_word", wordsB[0], 11'h103);
        wordsB.delete();
        applyStimulus(1, frame8E1(8'h03, 1'b0), 11, 2);
        checkOutput("even_good_count", wordsB.size(), 1);
        checkOutput("even_good_word", wordsB[0], 11'h003);
        checkOutput("even_no_overflow", overflowB, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end
endmodule
